floor_div_recon_16: RTL and testbench
=====================================

// Module: floor_div_recon_16
// PURPOSE
//   Inverse of the 16-bit floor divider: rebuilds the dividend from a
//   (quotient, divisor, remainder) triple as dividend = quotient*divisor + remainder.
//   Iterative shift-add engine, one quotient bit per cycle, valid/ready on both sides.
//   Sits behind the divider in the flopped benchmark harness as a round-trip
//   checker source. Also serves as a sequential multiply-add PPA point.
// PARAMETERS
//   BITWIDTH   16   width of quotient, divisor and remainder; dividend is 2*BITWIDTH
// PORTS
//   clk        in   1           single clock, all state on posedge
//   rst_n      in   1           asynchronous, active-low reset
//   in_valid   in   1           operand triple valid
//   in_ready   out  1           engine idle, can accept operands
//   quotient   in   BITWIDTH    unsigned floor quotient
//   divisor    in   BITWIDTH    unsigned divisor
//   remainder  in   BITWIDTH    unsigned remainder
//   out_valid  out  1           result valid, held until out_ready
//   out_ready  in   1           downstream accepts result
//   dividend   out  2*BITWIDTH  quotient*divisor + remainder
//   div_zero   out  1           captured divisor == 0
//   rem_err    out  1           captured remainder >= divisor (invalid floor triple)
// BEHAVIOUR
//   Reset (async assert, sync release): state=IDLE; in_ready=1; out_valid=0;
//     dividend, div_zero, rem_err and all internal registers = 0.
//   FSM IDLE -> BUSY -> DONE -> IDLE. No overlap of ops.
//   IDLE:
//     in_ready=1. On in_valid && in_ready edge: capture operands.
//     acc = zero-extended remainder; mcand = zero-extended divisor; mplier = quotient.
//     cnt=0; flags computed from the captured values; go to BUSY.
//   BUSY:
//     in_ready=0. Each edge: if mplier[0], acc += mcand (2*BITWIDTH, no carry-out).
//     mcand <<= 1; mplier >>= 1; cnt++.
//     On the edge with cnt==BITWIDTH-1, go to DONE.
//     The final accumulate on that edge is included in dividend.
//   DONE:
//     out_valid=1. dividend=acc, div_zero and rem_err stable while out_valid && !out_ready.
//     On out_valid && out_ready edge: out_valid=0, go to IDLE.
//     dividend and flags keep their last value until the next result.
//   Latency: out_valid rises exactly BITWIDTH edges after the accepting edge.
//     Minimum issue interval is BITWIDTH+2 cycles (out_ready held 1).
//   Width: max result (2^B-1)^2 + (2^B-1) = 2^2B - 2^B fits 2*BITWIDTH bits; never overflows.
//   divisor==0: computation still runs and dividend = remainder. div_zero=1 and rem_err=1.
//   in_valid while not in IDLE: ignored, operands not sampled. Upstream holds them.
//   Input operand changes after the accept edge have no effect on the result.
//   Reset mid-BUSY or mid-DONE: the op is discarded; outputs return to reset values
//     immediately (async).
// TESTING
//   T1 Basic result and latency:
//     q=7, b=3, r=2 -> dividend=23, div_zero=0, rem_err=0.
//     out_valid rises 16 edges after accept.
//   T2 Maximum operands:
//     q=0xFFFF, b=0xFFFF, r=0xFFFE -> dividend=0xFFFEFFFF, rem_err=0.
//   T3 Zero divisor:
//     q=5, b=0, r=9 -> dividend=9, div_zero=1, rem_err=1.
//     T3 follow-up, invalid remainder: q=1, b=4, r=4 -> dividend=8, rem_err=1.
//   T4 Backpressure:
//     out_ready=0 for 5 cycles in DONE -> dividend and flags stable; in_ready=0.
//     A new in_valid during the stall is not accepted.
//     Release -> IDLE next edge.
//   T5 Reset mid-operation:
//     rst_n low at BUSY cnt=8 -> out_valid=0, dividend=0, in_ready=1.
//     After release, q=100, b=100, r=99 -> dividend=10099.
//   T6 Back-to-back issue:
//     out_ready=1, in_valid held with two triples -> second accept exactly 18 cycles
//     after the first; both results correct vs model a=q*b+r.

Source files
------------

// File: rtl/floor_div_recon_16.sv
// Rebuilds a floor-division dividend as quotient*divisor + remainder using an
// iterative shift-add engine that retires one quotient bit per cycle.
module floor_div_recon_16 #(
    parameter int BITWIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [BITWIDTH-1:0]     quotient,
    input  logic [BITWIDTH-1:0]     divisor,
    input  logic [BITWIDTH-1:0]     remainder,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [2*BITWIDTH-1:0]   dividend,
    output logic                    div_zero,
    output logic                    rem_err
);

    localparam int CNT_W = (BITWIDTH > 1) ? $clog2(BITWIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [2*BITWIDTH-1:0]  acc;
    logic [2*BITWIDTH-1:0]  mcand;
    logic [2*BITWIDTH-1:0]  acc_sum;
    logic [BITWIDTH-1:0]    mplier;
    logic [CNT_W-1:0]       cnt;
    logic                   zero_cap;
    logic                   rerr_cap;
    logic                   last;

    assign last    = (cnt == CNT_W'(BITWIDTH - 1));
    assign acc_sum = mplier[0] ? (acc + mcand) : acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = BUSY;
            BUSY:    if (last)      state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // Flags are captured at accept but only published with the result, so the
    // visible outputs keep describing the previous result until the next one lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            cnt      <= '0;
            zero_cap <= 1'b0;
            rerr_cap <= 1'b0;
            dividend <= '0;
            div_zero <= 1'b0;
            rem_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        acc      <= {{BITWIDTH{1'b0}}, remainder};
                        mcand    <= {{BITWIDTH{1'b0}}, divisor};
                        mplier   <= quotient;
                        cnt      <= '0;
                        zero_cap <= (divisor == '0);
                        rerr_cap <= (remainder >= divisor);
                    end
                end
                BUSY: begin
                    acc    <= acc_sum;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CNT_W'(1);
                    if (last) begin
                        dividend <= acc_sum;
                        div_zero <= zero_cap;
                        rem_err  <= rerr_cap;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_floor_div_recon_16.sv
// Randomized and directed bench for floor_div_recon_16 against an arithmetic model.
module tb_floor_div_recon_16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [15:0] quotient = '0;
    logic [15:0] divisor = '0;
    logic [15:0] remainder = '0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] dividend;
    logic        div_zero;
    logic        rem_err;

    int n_vec = 0;
    int n_err = 0;

    floor_div_recon_16 #(.BITWIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .quotient  (quotient),
        .divisor   (divisor),
        .remainder (remainder),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dividend  (dividend),
        .div_zero  (div_zero),
        .rem_err   (rem_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model_div(input logic [15:0] q, b, r);
        longint unsigned v;
        v = longint'(q) * longint'(b) + longint'(r);
        return v[31:0];
    endfunction

    // Presents one triple, waits for acceptance and for the result; all waits bounded.
    task automatic do_op(input logic [15:0] q, b, r,
                         output logic [31:0] d, output logic dz, re, output int lat);
        int w;
        w = 0;
        quotient = q; divisor = b; remainder = r; in_valid = 1'b1;
        while (!in_ready && w < 40) begin
            @(posedge clk); #1; w++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        quotient = 16'($urandom); divisor = 16'($urandom); remainder = 16'($urandom);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        d = dividend; dz = div_zero; re = rem_err;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        n_vec++; if (dividend !== 32'd0) begin n_err++; $display("FAIL reset_dividend got=%0d exp=0", dividend); end
        n_vec++; if ({div_zero, rem_err} !== 2'b00) begin n_err++; $display("FAIL reset_flags got=%b exp=00", {div_zero, rem_err}); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_vec++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_err++; $display("FAIL post_reset_idle got=%b%b exp=10", in_ready, out_valid); end
    endtask

    task automatic test_basic;
        logic [31:0] d; logic dz, re; int lat;
        do_op(16'd7, 16'd3, 16'd2, d, dz, re, lat);
        n_vec++; if (lat !== 16) begin n_err++; $display("FAIL basic_latency got=%0d exp=16", lat); end
        n_vec++; if (d !== 32'd23) begin n_err++; $display("FAIL basic_dividend got=%0d exp=23", d); end
        n_vec++; if ({dz, re} !== 2'b00) begin n_err++; $display("FAIL basic_flags got=%b exp=00", {dz, re}); end
        @(posedge clk); #1;
    endtask

    task automatic test_max;
        logic [31:0] d; logic dz, re; int lat;
        do_op(16'hFFFF, 16'hFFFF, 16'hFFFE, d, dz, re, lat);
        n_vec++; if (d !== 32'hFFFEFFFF || lat !== 16) begin n_err++; $display("FAIL max_dividend got=%h lat=%0d exp=fffeffff lat=16", d, lat); end
        n_vec++; if ({dz, re} !== 2'b00) begin n_err++; $display("FAIL max_flags got=%b exp=00", {dz, re}); end
        @(posedge clk); #1;
    endtask

    task automatic test_zero_div;
        logic [31:0] d; logic dz, re; int lat;
        do_op(16'd5, 16'd0, 16'd9, d, dz, re, lat);
        n_vec++; if (d !== 32'd9 || lat !== 16) begin n_err++; $display("FAIL zdiv_dividend got=%0d lat=%0d exp=9 lat=16", d, lat); end
        n_vec++; if ({dz, re} !== 2'b11) begin n_err++; $display("FAIL zdiv_flags got=%b exp=11", {dz, re}); end
        @(posedge clk); #1;
        do_op(16'd1, 16'd4, 16'd4, d, dz, re, lat);
        n_vec++; if (d !== 32'd8) begin n_err++; $display("FAIL remerr_dividend got=%0d exp=8", d); end
        n_vec++; if ({dz, re} !== 2'b01) begin n_err++; $display("FAIL remerr_flags got=%b exp=01", {dz, re}); end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure;
        logic [31:0] d; logic dz, re; int lat;
        logic [31:0] exp_d;
        exp_d = model_div(16'd1234, 16'd567, 16'd89);
        out_ready = 1'b0;
        do_op(16'd1234, 16'd567, 16'd89, d, dz, re, lat);
        n_vec++; if (d !== exp_d || lat !== 16) begin n_err++; $display("FAIL bp_result got=%0d lat=%0d exp=%0d lat=16", d, lat, exp_d); end
        quotient = 16'd3; divisor = 16'd3; remainder = 16'd0; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_vec++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || dividend !== exp_d || {div_zero, rem_err} !== 2'b00) begin
                n_err++;
                $display("FAIL bp_stall cyc=%0d got ov=%b ir=%b d=%0d f=%b exp ov=1 ir=0 d=%0d f=00",
                         i, out_valid, in_ready, dividend, {div_zero, rem_err}, exp_d);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_vec++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release got ov=%b ir=%b exp ov=0 ir=1", out_valid, in_ready); end
        n_vec++; if (dividend !== exp_d) begin n_err++; $display("FAIL bp_hold got=%0d exp=%0d", dividend, exp_d); end
        repeat (20) @(posedge clk);
        #1;
        n_vec++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL bp_no_accept got ov=%b ir=%b exp ov=0 ir=1", out_valid, in_ready); end
    endtask

    task automatic test_reset_mid;
        logic [31:0] d; logic dz, re; int lat;
        int w;
        w = 0;
        quotient = 16'd300; divisor = 16'd200; remainder = 16'd100; in_valid = 1'b1;
        while (!in_ready && w < 40) begin @(posedge clk); #1; w++; end
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_vec++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL midrst_ctrl got ov=%b ir=%b exp ov=0 ir=1", out_valid, in_ready); end
        n_vec++; if (dividend !== 32'd0) begin n_err++; $display("FAIL midrst_dividend got=%0d exp=0", dividend); end
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        do_op(16'd100, 16'd100, 16'd99, d, dz, re, lat);
        n_vec++; if (d !== 32'd10099 || lat !== 16) begin n_err++; $display("FAIL midrst_after got=%0d lat=%0d exp=10099 lat=16", d, lat); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        logic [15:0] q[2], b[2], r[2];
        int acc_at[2];
        logic [31:0] res[4];
        int nacc, nres;
        logic accepting;
        q[0] = 16'($urandom); b[0] = 16'($urandom); r[0] = 16'($urandom_range(0, 1000));
        q[1] = 16'($urandom); b[1] = 16'($urandom); r[1] = 16'($urandom_range(0, 1000));
        nacc = 0; nres = 0; acc_at[0] = -1; acc_at[1] = -1;
        out_ready = 1'b1;
        quotient = q[0]; divisor = b[0]; remainder = r[0]; in_valid = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if (out_valid && nres < 4) begin res[nres] = dividend; nres++; end
            accepting = in_valid && in_ready;
            @(posedge clk); #1;
            if (accepting && nacc < 2) begin
                acc_at[nacc] = i;
                nacc++;
                if (nacc == 1) begin quotient = q[1]; divisor = b[1]; remainder = r[1]; end
                else begin in_valid = 1'b0; quotient = 16'($urandom); end
            end
        end
        in_valid = 1'b0;
        n_vec++; if (nacc !== 2 || acc_at[1] - acc_at[0] !== 18) begin n_err++; $display("FAIL b2b_interval got=%0d accepts=%0d exp=18 accepts=2", acc_at[1] - acc_at[0], nacc); end
        n_vec++; if (nres !== 2) begin n_err++; $display("FAIL b2b_count got=%0d exp=2", nres); end
        for (int k = 0; k < 2; k++) begin
            n_vec++;
            if (nres <= k || res[k] !== model_div(q[k], b[k], r[k])) begin
                n_err++;
                $display("FAIL b2b_result%0d got=%0d exp=%0d", k, (nres > k) ? res[k] : 32'd0, model_div(q[k], b[k], r[k]));
            end
        end
    endtask

    task automatic test_random;
        logic [31:0] d; logic dz, re; int lat;
        logic [15:0] q, b, r;
        for (int i = 0; i < 24; i++) begin
            q = 16'($urandom);
            b = (i % 6 == 5) ? 16'd0 : 16'($urandom_range(0, (i % 2) ? 65535 : 300));
            r = 16'($urandom_range(0, (i % 3) ? 400 : 65535));
            out_ready = 1'b1;
            do_op(q, b, r, d, dz, re, lat);
            n_vec++;
            if (d !== model_div(q, b, r) || dz !== (b == 16'd0) || re !== (r >= b) || lat !== 16) begin
                n_err++;
                $display("FAIL rand%0d q=%0d b=%0d r=%0d got d=%0d f=%b%b lat=%0d exp d=%0d f=%b%b lat=16",
                         i, q, b, r, d, dz, re, lat, model_div(q, b, r), (b == 16'd0), (r >= b));
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_max();
        test_zero_div();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
